ahb_param_arbiter: RTL and testbench

//  Parametrised AHB-Lite multi-master arbiter for the generated AHB_bus interconnect.
//  - Fills the arbitration slot of the bus, one instance per shared slave/bus segment.
//  - Supports N_MAS masters, fixed-priority or round-robin mode, burst-aware grant holding.
//  - Handles locked transfers and an optional INCR hold limit.
//  - Drives one-hot grant, address-phase owner and data-phase owner for the bus muxes.

---
 rtl/ahb_param_arbiter_pkg.sv | 40 ++++
 rtl/ahb_param_arbiter_picker.sv | 40 ++++
 rtl/ahb_param_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ahb_param_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ahb_param_arbiter_pkg.sv
// Shared AHB encodings and helpers for the arbiter slice.
package ahb_param_arbiter_pkg;

   typedef enum logic [1:0] {
      HtIdle   = 2'b00,
      HtBusy   = 2'b01,
      HtNonseq = 2'b10,
      HtSeq    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      HbSingle = 3'b000,
      HbIncr   = 3'b001,
      HbWrap4  = 3'b010,
      HbIncr4  = 3'b011,
      HbWrap8  = 3'b100,
      HbIncr8  = 3'b101,
      HbWrap16 = 3'b110,
      HbIncr16 = 3'b111
   } hburst_t;

   typedef enum logic [1:0] {
      StArb,
      StBurst,
      StLock
   } arb_state_t;

   localparam int unsigned BeatCntW = 5;

   // Beats in a fixed-length burst; SINGLE and undefined-length INCR report 1.
   function automatic logic [BeatCntW-1:0] burst_len(input hburst_t burst);
      case (burst)
         HbWrap4, HbIncr4:   burst_len = 5'd4;
         HbWrap8, HbIncr8:   burst_len = 5'd8;
         HbWrap16, HbIncr16: burst_len = 5'd16;
         default:            burst_len = 5'd1;
      endcase
   endfunction

endpackage

// File: rtl/ahb_param_arbiter_picker.sv
// Combinational winner picker: fixed priority (lowest index) or round robin
// starting one past rr_ptr. Only indices below N_MAS are ever considered.
module ahb_param_arbiter_picker #(
   parameter int unsigned N_MAS = 4,
   parameter int unsigned MODE  = 1,
   localparam int unsigned MW   = $clog2(N_MAS)
) (
   input  logic [N_MAS-1:0] req,
   input  logic [MW-1:0]    rr_ptr,
   output logic [MW-1:0]    winner,
   output logic             valid
);

   int unsigned      idx;
   logic [MW-1:0]    idx_w;

   // Scan candidates in priority order; the first requester wins.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = 0;
      idx_w  = '0;
      for (int unsigned i = 0; i < N_MAS; i++) begin
         if (MODE == 1) begin
            idx = 32'(rr_ptr) + i + 1;
            if (idx >= N_MAS) begin
               idx = idx - N_MAS;
            end
         end else begin
            idx = i;
         end
         idx_w = idx[MW-1:0];
         if (!valid && req[idx_w]) begin
            valid  = 1'b1;
            winner = idx_w;
         end
      end
   end

endmodule

// File: rtl/ahb_param_arbiter.sv
// AHB-Lite multi-master arbiter: burst-aware grant holding, locked transfers,
// optional INCR hold limit, address- and data-phase owner outputs.
// MAX_HOLD is expected to be 0 (unlimited) or 2..31.
module ahb_param_arbiter
   import ahb_param_arbiter_pkg::*;
#(
   parameter int unsigned N_MAS    = 4,
   parameter int unsigned MODE     = 1,
   parameter int unsigned DEF_MAS  = 0,
   parameter int unsigned MAX_HOLD = 16,
   localparam int unsigned MW      = $clog2(N_MAS)
) (
   input  logic             hclk,
   input  logic             hreset_n,
   input  logic [N_MAS-1:0] hbusreq,
   input  logic [N_MAS-1:0] hlock,
   input  logic [1:0]       htrans,
   input  logic [2:0]       hburst,
   input  logic             hready,
   output logic [N_MAS-1:0] hgrant,
   output logic [MW-1:0]    hmaster,
   output logic [MW-1:0]    hmaster_d,
   output logic             hmastlock
);

   localparam logic [MW-1:0]       DefMas   = MW'(DEF_MAS);
   localparam logic [BeatCntW-1:0] HoldLast = (MAX_HOLD == 0) ? '0 : BeatCntW'(MAX_HOLD - 1);

   arb_state_t          state_q, state_d;
   logic [BeatCntW-1:0] beat_cnt_q, beat_cnt_d;
   logic [BeatCntW-1:0] len_q, len_d;
   logic                incr_q, incr_d;
   logic [MW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [MW-1:0]       owner_q, owner_d;
   logic [MW-1:0]       owner_dp_q;

   htrans_t       trans;
   hburst_t       burst;
   logic [MW-1:0] pick_winner;
   logic          pick_valid;
   logic [MW-1:0] arb_owner;
   logic          rearb;

   assign trans = htrans_t'(htrans);
   assign burst = hburst_t'(hburst);

   ahb_param_arbiter_picker #(
      .N_MAS (N_MAS),
      .MODE  (MODE)
   ) u_picker (
      .req    (hbusreq),
      .rr_ptr (rr_ptr_q),
      .winner (pick_winner),
      .valid  (pick_valid)
   );

   assign arb_owner = pick_valid ? pick_winner : DefMas;

   // Next-state: decide whether the current owner keeps the bus or re-arbitration happens now.
   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      len_d      = len_q;
      incr_d     = incr_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      rearb      = 1'b0;

      case (state_q)
         StArb: begin
            if (hlock[owner_q] && hbusreq[owner_q] && trans == HtNonseq) begin
               state_d = StLock;
            end else if (trans == HtNonseq && burst != HbSingle) begin
               state_d    = StBurst;
               beat_cnt_d = 5'd1;
               len_d      = burst_len(burst);
               incr_d     = (burst == HbIncr);
            end else begin
               rearb = 1'b1;
            end
         end

         StBurst: begin
            case (trans)
               HtSeq: begin
                  if (!incr_q && beat_cnt_q == len_q - 5'd1) begin
                     rearb = 1'b1;
                  end else if (incr_q && MAX_HOLD != 0 && beat_cnt_q == HoldLast) begin
                     rearb = 1'b1;
                  end else if (beat_cnt_q != '1) begin
                     beat_cnt_d = beat_cnt_q + 5'd1;
                  end
               end
               HtNonseq: begin
                  // NONSEQ ends an INCR; inside a fixed burst it restarts a burst for the same owner.
                  if (incr_q || burst == HbSingle) begin
                     rearb = 1'b1;
                  end else begin
                     beat_cnt_d = 5'd1;
                     len_d      = burst_len(burst);
                     incr_d     = (burst == HbIncr);
                  end
               end
               // IDLE only shows up mid fixed burst after an early termination; free the bus.
               HtIdle:  rearb = 1'b1;
               default: ;
            endcase
         end

         StLock: begin
            if (!hlock[owner_q]) begin
               rearb = 1'b1;
            end
         end

         default: rearb = 1'b1;
      endcase

      if (rearb) begin
         state_d    = StArb;
         beat_cnt_d = '0;
         owner_d    = arb_owner;
      end

      if (MODE == 1 && owner_d != owner_q) begin
         rr_ptr_d = owner_d;
      end
   end

   // State register: synchronous reset, everything holds while hready is low.
   always_ff @(posedge hclk) begin
      if (!hreset_n) begin
         state_q    <= StArb;
         beat_cnt_q <= '0;
         len_q      <= 5'd1;
         incr_q     <= 1'b0;
         rr_ptr_q   <= DefMas;
         owner_q    <= DefMas;
         owner_dp_q <= DefMas;
      end else if (hready) begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         len_q      <= len_d;
         incr_q     <= incr_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         owner_dp_q <= owner_q;
      end
   end

   // Outputs decode straight from registered state.
   always_comb begin
      hgrant    = {{(N_MAS-1){1'b0}}, 1'b1} << owner_q;
      hmaster   = owner_q;
      hmaster_d = owner_dp_q;
      hmastlock = (state_q == StLock);
   end

   // Bus muxes rely on exactly one grant at a time.
   assert property (@(posedge hclk) disable iff (!hreset_n) $onehot(hgrant));

endmodule

// File: tb/tb_ahb_param_arbiter.sv
// Directed bench for ahb_param_arbiter: one round-robin and one fixed-priority instance.
module tb_ahb_param_arbiter;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] SEQ    = 2'b11;
   localparam logic [2:0] SINGLE = 3'b000;
   localparam logic [2:0] INCR   = 3'b001;
   localparam logic [2:0] WRAP8  = 3'b100;
   localparam logic [2:0] INCR8  = 3'b101;

   logic       hclk = 1'b0;
   logic       hreset_n;
   logic [3:0] hbusreq;
   logic [3:0] hlock;
   logic [1:0] htrans;
   logic [2:0] hburst;
   logic       hready;

   logic [3:0] g_rr, g_fp;
   logic [1:0] m_rr, m_fp, md_rr, md_fp;
   logic       ml_rr, ml_fp;

   int errors = 0;
   int checks = 0;

   always #5 hclk = ~hclk;

   ahb_param_arbiter #(
      .N_MAS    (4),
      .MODE     (1),
      .DEF_MAS  (0),
      .MAX_HOLD (16)
   ) dut_rr (
      .hclk      (hclk),
      .hreset_n  (hreset_n),
      .hbusreq   (hbusreq),
      .hlock     (hlock),
      .htrans    (htrans),
      .hburst    (hburst),
      .hready    (hready),
      .hgrant    (g_rr),
      .hmaster   (m_rr),
      .hmaster_d (md_rr),
      .hmastlock (ml_rr)
   );

   ahb_param_arbiter #(
      .N_MAS    (4),
      .MODE     (0),
      .DEF_MAS  (0),
      .MAX_HOLD (16)
   ) dut_fp (
      .hclk      (hclk),
      .hreset_n  (hreset_n),
      .hbusreq   (hbusreq),
      .hlock     (hlock),
      .htrans    (htrans),
      .hburst    (hburst),
      .hready    (hready),
      .hgrant    (g_fp),
      .hmaster   (m_fp),
      .hmaster_d (md_fp),
      .hmastlock (ml_fp)
   );

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      hreset_n = 1'b0;
      hbusreq  = 4'b0000;
      hlock    = 4'b0000;
      htrans   = IDLE;
      hburst   = SINGLE;
      hready   = 1'b1;
      tick();
      hreset_n = 1'b1;
   endtask

   task automatic drive(input logic [3:0] req, input logic [3:0] lck, input logic [1:0] tr,
                        input logic [2:0] bu, input logic rdy);
      hbusreq = req;
      hlock   = lck;
      htrans  = tr;
      hburst  = bu;
      hready  = rdy;
   endtask

   initial begin
      // Reset held 3 clocks with random inputs.
      hreset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         hbusreq = 4'($urandom);
         hlock   = 4'($urandom);
         htrans  = 2'($urandom);
         hburst  = 3'($urandom);
         hready  = 1'($urandom);
         tick();
      end
      chk("rst_grant", 32'(g_rr), 1);
      chk("rst_mastlock", 32'(ml_rr), 0);
      chk("rst_master_d", 32'(md_rr), 0);
      chk("rst_master", 32'(m_rr), 0);
      chk("rst_grant_fp", 32'(g_fp), 1);

      // Round robin fairness with SINGLE NONSEQ transfers from everyone.
      hreset_n = 1'b1;
      drive(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1);
      tick(); chk("rr_e1", 32'(m_rr), 1); chk("rr_e1_d", 32'(md_rr), 0);
      tick(); chk("rr_e2", 32'(m_rr), 2); chk("rr_e2_d", 32'(md_rr), 1);
      tick(); chk("rr_e3", 32'(m_rr), 3); chk("rr_e3_grant", 32'(g_rr), 8);
      tick(); chk("rr_e4", 32'(m_rr), 0); chk("rr_e4_d", 32'(md_rr), 3);
      tick(); chk("rr_e5", 32'(m_rr), 1); chk("rr_e5_grant", 32'(g_rr), 2);
      // hready low freezes everything.
      hready = 1'b0;
      tick(); chk("stall_master", 32'(m_rr), 1); chk("stall_master_d", 32'(md_rr), 0);
      // Nobody requests: default master.
      drive(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
      tick(); chk("norq_grant", 32'(g_rr), 1); chk("norq_master_d", 32'(md_rr), 1);
      // Sole requester keeps the bus.
      drive(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1);
      tick(); chk("sole_1", 32'(m_rr), 2);
      tick(); chk("sole_2", 32'(m_rr), 2);

      // Burst hold: M2 INCR8 with M1 requesting and 2 wait states after beat 3.
      do_reset();
      drive(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1);
      tick(); chk("bh_own", 32'(m_rr), 2);
      drive(4'b0110, 4'b0000, NONSEQ, INCR8, 1'b1);
      tick(); chk("bh_b1", 32'(m_rr), 2);
      htrans = SEQ;
      tick(); chk("bh_b2", 32'(m_rr), 2);
      tick(); chk("bh_b3", 32'(m_rr), 2);
      hready = 1'b0;
      tick(); chk("bh_ws1", 32'(g_rr), 4);
      tick(); chk("bh_ws2", 32'(g_rr), 4);
      hready = 1'b1;
      tick(); chk("bh_b4", 32'(m_rr), 2);
      tick(); chk("bh_b5", 32'(m_rr), 2);
      tick(); chk("bh_b6", 32'(m_rr), 2);
      tick(); chk("bh_b7", 32'(g_rr), 4);
      tick(); chk("bh_b8_master", 32'(m_rr), 1);
      chk("bh_b8_grant", 32'(g_rr), 2);
      chk("bh_b8_master_d", 32'(md_rr), 2);
      drive(4'b0010, 4'b0000, NONSEQ, SINGLE, 1'b1);
      tick(); chk("bh_after_d", 32'(md_rr), 1);

      // INCR hold limit: M0 streams, M3 requests; release on the 16th beat.
      do_reset();
      drive(4'b1001, 4'b0000, NONSEQ, INCR, 1'b1);
      tick(); chk("incr_b1", 32'(m_rr), 0);
      htrans = SEQ;
      for (int b = 2; b <= 15; b++) begin
         tick();
      end
      chk("incr_b15", 32'(m_rr), 0);
      tick(); chk("incr_b16", 32'(m_rr), 3);
      chk("incr_b16_grant", 32'(g_rr), 8);

      // Lock, fixed priority: M1 owns and locks, M0 waits until the lock drops.
      do_reset();
      drive(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1);
      tick(); chk("lk_own", 32'(m_fp), 1);
      drive(4'b0011, 4'b0010, NONSEQ, SINGLE, 1'b1);
      tick(); chk("lk_t1_lock", 32'(ml_fp), 1); chk("lk_t1_master", 32'(m_fp), 1);
      tick(); chk("lk_t2_lock", 32'(ml_fp), 1); chk("lk_t2_master", 32'(m_fp), 1);
      tick(); chk("lk_t3_lock", 32'(ml_fp), 1); chk("lk_t3_grant", 32'(g_fp), 2);
      hlock = 4'b0000;
      tick(); chk("lk_rel_lock", 32'(ml_fp), 0); chk("lk_rel_grant", 32'(g_fp), 1);
      // Fixed priority: lowest requester wins.
      drive(4'b1100, 4'b0000, IDLE, SINGLE, 1'b1);
      tick(); chk("fp_low", 32'(m_fp), 2);

      // Reset on beat 3 of a WRAP8 from M3.
      do_reset();
      drive(4'b1000, 4'b0000, IDLE, SINGLE, 1'b1);
      tick(); chk("rb_own", 32'(m_rr), 3);
      drive(4'b1000, 4'b0000, NONSEQ, WRAP8, 1'b1);
      tick();
      htrans = SEQ;
      tick();
      hreset_n = 1'b0;
      tick(); chk("rb_grant", 32'(g_rr), 1); chk("rb_master_d", 32'(md_rr), 0);
      chk("rb_lock", 32'(ml_rr), 0);
      // Back in ARB: a stray SEQ re-arbitrates instead of counting beats.
      hreset_n = 1'b1;
      tick(); chk("rb_arb", 32'(m_rr), 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
